// File: rtl/riscv_pkg.sv
// Shared RISC-V fetch/decode definitions: fetch FSM states, default widths,
// reset PC, the canonical NOP and the base-ISA major opcodes.
package riscv_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN,
    S_HALT
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch unit: requests one word, holds it for
// decode, then advances the PC or follows a redirect.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [6:0]      opcode,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            misaligned_err
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            err_q, err_d;
  logic            redir_ok, redir_bad;

  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] a);
    return a + XLEN'(4);
  endfunction

  assign redir_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
  assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= XLEN'(NOP_INSTR);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    err_d   = err_q;
    if (state_q != S_HALT && redir_bad) begin
      state_d = S_HALT;
      err_d   = 1'b1;
    end else begin
      if (state_q != S_HALT && redir_ok)
        pc_d = redirect_pc;
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          // A redirect accepted alongside gnt still leaves one response in flight
          if (imem_gnt)
            state_d = redir_ok ? S_DRAIN : S_WAIT;
        end
        S_WAIT: begin
          if (redir_ok)
            state_d = imem_rvalid ? S_REQ : S_DRAIN;
          else if (imem_rvalid) begin
            instr_d = imem_rdata;
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (redir_ok)
            state_d = S_REQ;
          else if (instr_ready) begin
            pc_d    = pc_inc(pc_q);
            state_d = S_REQ;
          end
        end
        S_DRAIN: begin
          if (imem_rvalid)
            state_d = S_REQ;
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign imem_req       = (state_q == S_REQ);
  assign imem_addr      = pc_q;
  assign instr_valid    = (state_q == S_HOLD);
  assign instr          = instr_q;
  assign opcode         = instr_q[6:0];
  assign pc             = pc_q;
  assign pc_plus4       = pc_inc(pc_q);
  assign misaligned_err = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a zero-wait memory responder, directed
// stimulus pushing expected fetches, and a monitor checking each consumed word.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misaligned_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  logic        pending;
  logic [31:0] pend_addr;
  bit          gnt_en = 1'b1;
  bit          rv_override = 1'b0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .opcode        (opcode),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .misaligned_err(misaligned_err)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Memory contents: word at address a is (a << 8) | 0x33.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 8) | 32'h0000_0033;
  endfunction

  // Zero-wait memory: grant while requested, return data on the following cycle.
  initial begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    pending     = 1'b0;
    pend_addr   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rv_override) begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_0013;
        pending     = 1'b0;
      end else begin
        imem_rvalid = pending;
        imem_rdata  = pending ? mem_word(pend_addr) : 32'h0;
        pending     = 1'b0;
        if (imem_req && gnt_en) begin
          imem_gnt  = 1'b1;
          pending   = 1'b1;
          pend_addr = imem_addr;
        end else begin
          imem_gnt = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && instr_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: instr %h pc %h presented with nothing expected", instr, pc);
      end else if (instr_ready) begin
        e = exp_q.pop_front();
        chk("instr", instr, e.word);
        chk("pc", pc, e.pc);
        chk("pc_plus4", pc_plus4, e.pc + 32'd4);
        chk("opcode", {25'b0, opcode}, {25'b0, e.word[6:0]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input logic [31:0] p, input logic [31:0] w);
    exp_t x;
    x.pc   = p;
    x.word = w;
    exp_q.push_back(x);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!instr_valid) begin
      errors++;
      $display("FAIL %s: instr_valid 0 after 20 cycles, required 1", name);
    end
  endtask

  task automatic accept();
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (3) tick();
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_err", 32'(misaligned_err), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_instr", instr, 32'h0000_0013);

    // First fetch after reset with zero-wait memory
    rst_n = 1'b1;
    push_exp(32'h0, 32'h0000_0033);
    tick();
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    tick();
    chk("wait_no_valid", 32'(instr_valid), 32'd0);
    chk("wait_no_req", 32'(imem_req), 32'd0);
    tick();
    chk("valid_third_edge", 32'(instr_valid), 32'd1);

    // Decode stalls for 5 cycles
    repeat (5) begin
      chk("hold_valid", 32'(instr_valid), 32'd1);
      chk("hold_instr", instr, 32'h0000_0033);
      chk("hold_pc", pc, 32'h0);
      chk("hold_no_req", 32'(imem_req), 32'd0);
      tick();
    end
    push_exp(32'h4, 32'h0000_0433);
    accept();
    chk("seq_addr", imem_addr, 32'h4);
    chk("seq_req", 32'(imem_req), 32'd1);
    wait_valid("valid_pc4");
    accept();

    // Redirect coinciding with gnt: the in-flight word must be dropped
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    chk("gnt_with_redirect", 32'(imem_gnt), 32'd1);
    tick();
    redirect_valid = 1'b0;
    chk("drain_no_req", 32'(imem_req), 32'd0);
    chk("drain_no_valid", 32'(instr_valid), 32'd0);
    tick();
    chk("redir_addr", imem_addr, 32'h0000_0100);
    chk("redir_req", 32'(imem_req), 32'd1);
    push_exp(32'h0000_0100, 32'h0001_0033);
    wait_valid("valid_redir");

    // Redirect beats a simultaneous ready, landing on the top word
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    instr_ready    = 1'b1;
    tick();
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    chk("prio_addr", imem_addr, 32'hFFFF_FFFC);
    chk("prio_no_valid", 32'(instr_valid), 32'd0);
    push_exp(32'hFFFF_FFFC, 32'hFFFF_FC33);
    wait_valid("valid_top");
    accept();
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_req", 32'(imem_req), 32'd1);
    push_exp(32'h0, 32'h0000_0033);
    wait_valid("valid_wrapped");
    accept();

    // Misaligned redirect halts the unit
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
    repeat (4) begin
      chk("halt_err", 32'(misaligned_err), 32'd1);
      chk("halt_no_req", 32'(imem_req), 32'd0);
      chk("halt_no_valid", 32'(instr_valid), 32'd0);
      chk("halt_pc_kept", imem_addr, 32'h4);
      tick();
    end
    rst_n = 1'b0;
    tick();
    chk("err_cleared", 32'(misaligned_err), 32'd0);

    // Reset in WAIT with rvalid during and just after reset
    rst_n = 1'b1;
    tick();
    chk("restart_req", 32'(imem_req), 32'd1);
    tick();
    chk("in_wait_no_req", 32'(imem_req), 32'd0);
    rst_n       = 1'b0;
    rv_override = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_0013;
    tick();
    tick();
    chk("rst2_instr", instr, 32'h0000_0013);
    chk("rst2_addr", imem_addr, 32'h0);
    rst_n = 1'b1;
    tick();
    tick();
    rv_override = 1'b0;
    imem_rvalid = 1'b0;
    chk("late_rvalid_req", 32'(imem_req), 32'd1);
    chk("late_rvalid_addr", imem_addr, 32'h0);
    chk("late_rvalid_no_valid", 32'(instr_valid), 32'd0);
    push_exp(32'h0, 32'h0000_0033);
    wait_valid("valid_after_reset");
    accept();
    tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter XLEN, default 32, SHALL set the PC and instruction width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 imem_req  output  1  SHALL request an instruction-memory read.
REQ-006 imem_addr  output  XLEN  SHALL carry the read address; valid while imem_req=1.
REQ-007 imem_gnt  input  1  SHALL indicate that the memory accepts the request this cycle.
REQ-008 imem_rvalid  input  1  SHALL indicate that imem_rdata is valid this cycle.
REQ-009 imem_rdata  input  XLEN  SHALL carry the returned instruction word.
REQ-010 instr_valid  output  1  SHALL indicate that instr, pc and opcode hold a fetched instruction for decode.
REQ-011 instr_ready  input  1  SHALL indicate that decode/control consumes the instruction this cycle.
REQ-012 instr  output  XLEN  SHALL carry the fetched instruction word.
REQ-013 opcode  output  7  SHALL equal instr[6:0] and feed the control decoder.
REQ-014 pc / pc_plus4  output  XLEN each  SHALL carry the instruction address and that address + 4.
REQ-015 redirect_valid  input  1  SHALL request a PC change (taken branch, JAL, JALR).
REQ-016 redirect_pc  input  XLEN  SHALL carry the redirect target.
REQ-017 misaligned_err  output  1  SHALL be a sticky flag for a rejected misaligned redirect.

Function
REQ-018 The FSM SHALL have the states IDLE, REQ, WAIT, HOLD, DRAIN and HALT.
REQ-019 In IDLE, the FSM SHALL go to REQ unconditionally on the next cycle.
REQ-020 In REQ: imem_req=1 and imem_addr=pc_q; on imem_gnt the FSM SHALL go to WAIT; imem_req and imem_addr SHALL stay stable until gnt.
REQ-021 In WAIT: on imem_rvalid the FSM SHALL register imem_rdata into instr and go to HOLD, so instr_valid rises the cycle after rvalid.
REQ-022 In HOLD: instr_valid=1 and instr/pc SHALL stay stable; on instr_ready, pc_q SHALL become pc_q+4 (modulo 2^XLEN, wrapping from 32'hFFFF_FFFC to 0) and the FSM SHALL go to REQ.
REQ-023 instr_valid SHALL be 1 only in HOLD; imem_req SHALL be 1 only in REQ.
REQ-024 redirect_valid with redirect_pc[1:0]==0 SHALL load pc_q with redirect_pc in any state except HALT, and SHALL take priority over a simultaneous instr_ready.
REQ-025 For a redirect in REQ without gnt, in HOLD, or in IDLE, the FSM SHALL go to REQ; instr_valid SHALL be 0 the next cycle.
REQ-026 For a redirect in WAIT, or in REQ with gnt in the same cycle, the FSM SHALL go to DRAIN.
REQ-027 In DRAIN, the FSM SHALL discard the outstanding response and go to REQ on imem_rvalid; a further redirect in DRAIN SHALL only update pc_q.
REQ-028 If rvalid coincides with a redirect in WAIT, the data SHALL be discarded and the FSM SHALL go to REQ.
REQ-029 A redirect with redirect_pc[1:0]!=0 SHALL leave pc_q unchanged, set misaligned_err=1, and send the FSM to HALT.
REQ-030 HALT SHALL be exit-only-by-reset, with imem_req=0 and instr_valid=0.
REQ-031 At most one memory request SHALL be outstanding at any time.
REQ-032 Best-case throughput SHALL be one instruction per 3 cycles (REQ->WAIT->HOLD) with zero-wait memory.

Reset
REQ-033 While rst_n=0: state=IDLE, pc_q=RESET_PC, instr=32'h0000_0013 (NOP), imem_req=0, instr_valid=0, misaligned_err=0, imem_addr=RESET_PC.
REQ-034 Reset asserted mid-transaction SHALL abandon the transaction immediately; a late imem_rvalid arriving in IDLE/REQ SHALL be ignored.

Structure
REQ-035 riscv_pkg SHALL hold the fetch_state_t enum, XLEN, RESET_PC default, the NOP encoding and the opcode constants shared with the control decoder.
REQ-036 The block SHALL be a single module with no sub-module; the PC adder SHALL be inline.

Verification
REQ-037 Check: release reset, 0-wait memory returning 32'h0000_0033 -> imem_addr=0 first, instr_valid 3 cycles after IDLE exit, opcode=7'b0110011, pc=0, pc_plus4=4.
REQ-038 Check: ready held low 5 cycles in HOLD -> instr/pc stable, no imem_req; ready pulse -> next imem_addr=4.
REQ-039 Check: redirect to 32'h0000_0100 in the same cycle as gnt -> DRAIN; the returned word is discarded, next imem_addr=0x100, and no instr_valid for the stale word.
REQ-040 Check: redirect to 32'h0000_0102 -> misaligned_err=1 sticky, imem_req=0 for good, pc unchanged; rst_n pulse clears it.
REQ-041 Check: pc_q=32'hFFFF_FFFC, instr_ready -> next imem_addr=0.
REQ-042 Check: rst_n asserted in WAIT, then rvalid during reset and the first cycle after release -> ignored, fetch restarts at RESET_PC.
